// File: rtl/ppu_sched.sv
// ppu_sched: front-end controller for the PPU.
//
// Purpose
//   Round-robin arbitration of two byte producers (host, seed/noise) onto the
//   single PPU byte port. A frame timer tracks the PPU raster, drives the
//   one-cycle sync pulse, and mode changes are deferred to the frame boundary
//   so a pattern switch never tears mid-frame.
//
// Ports
//   clk        system/pixel clock
//   rst        asynchronous active-low reset
//   s0_data/s0_stb/s0_ack   source 0 (host) byte handshake
//   s1_data/s1_stb/s1_ack   source 1 (seed/noise) byte handshake
//   ppu_data/ppu_stb        byte + one-cycle strobe towards the PPU
//   ppu_ack                 PPU accept
//   mode_wr/mode_req        load requested mode into the pending register
//   mode_o                  mode presented to the PPU, changes only at frame wrap
//   sync_o                  one-cycle pulse on the last pixel of the frame
//   frame_cnt               completed frames, natural 8-bit wrap
//   err_o/err_clr           sticky ack-timeout flag and its clear
//   state_dbg               current arbiter state (IDLE=0, ISSUE=1, WAIT=2)
//
// Handshake semantics
//   Sources raise sX_stb with sX_data stable and hold both until sX_ack, a
//   single-cycle pulse sent the cycle after the PPU accepted the byte. Towards
//   the PPU, ppu_stb is high for exactly one cycle with ppu_data valid and
//   ppu_data stays latched until the next grant; ppu_ack is only honoured in
//   WAIT. If the PPU does not ack within TIMEOUT cycles the byte is dropped
//   without an ack, err_o is set, and the still-requesting source competes
//   again under normal fairness.

module ppu_sched #(
   parameter int H_TOTAL = 800,
   parameter int V_TOTAL = 525,
   parameter int TIMEOUT = 15,
   parameter int TO_BITS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] s0_data,
   input  logic       s0_stb,
   output logic       s0_ack,
   input  logic [7:0] s1_data,
   input  logic       s1_stb,
   output logic       s1_ack,
   output logic [7:0] ppu_data,
   output logic       ppu_stb,
   input  logic       ppu_ack,
   input  logic       mode_wr,
   input  logic [2:0] mode_req,
   output logic [2:0] mode_o,
   output logic       sync_o,
   output logic [7:0] frame_cnt,
   output logic       err_o,
   input  logic       err_clr,
   output logic [1:0] state_dbg
);

   localparam logic [9:0]         H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0]         V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t             state;
   logic [9:0]         hcnt;
   logic [9:0]         vcnt;
   logic [9:0]         h_nxt;
   logic [9:0]         v_nxt;
   logic               frame_end;
   logic [2:0]         mode_pend;
   logic               last_grant;
   logic [TO_BITS-1:0] tcnt;
   logic               grant_valid;
   logic               grant_src;
   logic               timeout_hit;

   assign state_dbg = state;

   // ------------------------------------------------------------------
   // Frame timer
   // ------------------------------------------------------------------
   assign frame_end = (hcnt == H_LAST) && (vcnt == V_LAST);

   always_comb begin
      h_nxt = hcnt + 10'd1;
      v_nxt = vcnt;
      if (hcnt == H_LAST) begin
         h_nxt = '0;
         if (vcnt == V_LAST) v_nxt = '0;
         else                v_nxt = vcnt + 10'd1;
      end
   end

   // sync_o is computed from the next counter values so it is high during
   // exactly the cycle in which the counters sit on the last pixel.
   // mode_o samples the pending register with its old value, so a mode_wr
   // landing on the wrap cycle is only applied at the following wrap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hcnt      <= '0;
         vcnt      <= '0;
         sync_o    <= 1'b0;
         mode_pend <= '0;
         mode_o    <= '0;
         frame_cnt <= '0;
      end else begin
         hcnt   <= h_nxt;
         vcnt   <= v_nxt;
         sync_o <= (h_nxt == H_LAST) && (v_nxt == V_LAST);
         if (mode_wr) mode_pend <= mode_req;
         if (frame_end) begin
            mode_o    <= mode_pend;
            frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Arbiter
   // ------------------------------------------------------------------
   // No grant during the ack cycle: the acked source still shows its old
   // request that cycle and would otherwise be granted a stale byte.
   assign grant_valid = (s0_stb || s1_stb) && !(s0_ack || s1_ack);
   // Both requesting: the one not served last. Otherwise whoever asks.
   assign grant_src   = (s0_stb && s1_stb) ? ~last_grant : s1_stb;
   assign timeout_hit = (state == WAIT) && !ppu_ack && (tcnt == TO_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         ppu_data   <= '0;
         ppu_stb    <= 1'b0;
         s0_ack     <= 1'b0;
         s1_ack     <= 1'b0;
         last_grant <= 1'b1;
         tcnt       <= '0;
      end else begin
         s0_ack <= 1'b0;
         s1_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  ppu_data   <= grant_src ? s1_data : s0_data;
                  last_grant <= grant_src;
                  ppu_stb    <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               ppu_stb <= 1'b0;
               tcnt    <= '0;
               state   <= WAIT;
            end
            WAIT: begin
               if (ppu_ack) begin
                  // Ack goes to the granted source even if it dropped stb.
                  if (last_grant) s1_ack <= 1'b1;
                  else            s0_ack <= 1'b1;
                  state <= IDLE;
               end else begin
                  tcnt <= tcnt + 1'b1;
                  if (tcnt == TO_LAST) state <= IDLE;
               end
            end
            default: begin
               ppu_stb <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

   // Sticky error; a timeout on the same cycle as err_clr keeps it set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)             err_o <= 1'b0;
      else if (timeout_hit) err_o <= 1'b1;
      else if (err_clr)     err_o <= 1'b0;
   end

endmodule

// File: tb/tb_ppu_sched.sv
// Testbench for ppu_sched. A reduced 20x5 raster keeps frame-level checks short;
// the counter/compare logic is the same as for the full 800x525 raster.
module tb_ppu_sched;

   localparam int H     = 20;
   localparam int V     = 5;
   localparam int FRAME = H * V;

   // ---------------- clock / reset / DUT ----------------
   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] s0_data, s1_data, ppu_data;
   logic       s0_stb, s1_stb, s0_ack, s1_ack;
   logic       ppu_stb, ppu_ack;
   logic       mode_wr, sync_o, err_o, err_clr;
   logic [2:0] mode_req, mode_o;
   logic [7:0] frame_cnt;
   logic [1:0] state_dbg;

   always #5 clk = ~clk;

   ppu_sched #(.H_TOTAL(H), .V_TOTAL(V), .TIMEOUT(15), .TO_BITS(4)) dut (
      .clk(clk), .rst(rst),
      .s0_data(s0_data), .s0_stb(s0_stb), .s0_ack(s0_ack),
      .s1_data(s1_data), .s1_stb(s1_stb), .s1_ack(s1_ack),
      .ppu_data(ppu_data), .ppu_stb(ppu_stb), .ppu_ack(ppu_ack),
      .mode_wr(mode_wr), .mode_req(mode_req), .mode_o(mode_o),
      .sync_o(sync_o), .frame_cnt(frame_cnt),
      .err_o(err_o), .err_clr(err_clr), .state_dbg(state_dbg)
   );

   // ---------------- bookkeeping ----------------
   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
      cyc++;
   endtask

   task automatic tick_to(input int target);
      while (cyc < target) tick();
   endtask

   // ---------------- PPU model: acks one cycle after stb ----------------
   logic ack_en   = 1'b0;
   logic stb_prev = 1'b0;
   always @(negedge clk) begin
      ppu_ack  = ack_en && stb_prev;
      stb_prev = ppu_stb;
   end

   // ---------------- monitor + scoreboard ----------------
   logic [7:0] exp_q[$];
   logic [7:0] src_q[$];
   logic       sb_en      = 1'b0;
   logic       stb_last   = 1'b0;
   int         s0_ack_cnt = 0;
   int         s1_ack_cnt = 0;
   int         both_cnt   = 0;
   int         stb_double = 0;

   always @(negedge clk) begin
      if (s0_ack && s1_ack) both_cnt++;
      if (s0_ack) s0_ack_cnt++;
      if (s1_ack) s1_ack_cnt++;
      if (ppu_stb && stb_last) stb_double++;
      stb_last = ppu_stb;
      if (sb_en) begin
         if (ppu_stb) begin
            if (exp_q.size() == 0) chk("sb_extra_stb", 32'd1, 32'd0);
            else                   chk("sb_data", 32'(ppu_data), 32'(exp_q.pop_front()));
         end
         if (s0_ack || s1_ack) begin
            if (src_q.size() == 0) chk("sb_extra_ack", 32'd1, 32'd0);
            else                   chk("sb_src", 32'(s1_ack), 32'(src_q.pop_front()));
         end
      end
   end

   // ---------------- directed single-transfer vectors ----------------
   typedef struct {
      logic       s0;
      logic       s1;
      logic [7:0] d0;
      logic [7:0] d1;
      logic       exp_src;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs[8];

   // Runs one grant with the given requests; returns ack latency, source,
   // data seen with ppu_stb and number of stb cycles.
   task automatic run_xfer(output int lat, output logic src, output logic [7:0] seen,
                           output int stbn);
      lat  = -1;
      src  = 1'b0;
      seen = 8'h00;
      stbn = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (ppu_stb) begin
            stbn++;
            seen = ppu_data;
         end
         if (s0_ack || s1_ack) begin
            lat = k;
            src = s1_ack;
            break;
         end
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int         lat, stbn, a0, a1, i0, i1, first_sync, sync_cnt;
      logic       src;
      logic [7:0] seen;

      // last_grant starts at 1, so history: 0,1,0,1,1,0,0,1
      vecs[0] = '{1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, 8'hA5};
      vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h3C, 1'b1, 8'h3C};
      vecs[2] = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b0, 8'h11};
      vecs[3] = '{1'b1, 1'b1, 8'h33, 8'h44, 1'b1, 8'h44};
      vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h55, 1'b1, 8'h55};
      vecs[5] = '{1'b1, 1'b1, 8'h66, 8'h77, 1'b0, 8'h66};
      vecs[6] = '{1'b1, 1'b0, 8'h88, 8'h00, 1'b0, 8'h88};
      vecs[7] = '{1'b1, 1'b1, 8'h99, 8'hAA, 1'b1, 8'hAA};

      rst = 1'b0; s0_data = 0; s1_data = 0; s0_stb = 0; s1_stb = 0;
      mode_wr = 0; mode_req = 0; err_clr = 0;

      // ---- reset values ----
      repeat (3) tick();
      chk("rst_ppu_stb", 32'(ppu_stb), 0);
      chk("rst_ppu_data", 32'(ppu_data), 0);
      chk("rst_sync", 32'(sync_o), 0);
      chk("rst_mode", 32'(mode_o), 0);
      chk("rst_frame", 32'(frame_cnt), 0);
      chk("rst_err", 32'(err_o), 0);
      chk("rst_acks", 32'({s0_ack, s1_ack}), 0);
      chk("rst_state", 32'(state_dbg), 0);

      // ---- first frame: sync on the last pixel ----
      rst = 1'b1;
      cyc = 0;
      first_sync = -1;
      sync_cnt = 0;
      while (cyc < FRAME + 1) begin
         tick();
         if (sync_o) begin
            sync_cnt++;
            if (first_sync < 0) first_sync = cyc;
         end
      end
      chk("sync_first_cycle", 32'(first_sync), 32'(FRAME - 1));
      chk("sync_pulse_count", 32'(sync_cnt), 1);
      chk("frame_cnt_1", 32'(frame_cnt), 1);
      chk("mode_after_f1", 32'(mode_o), 0);

      // ---- mode deferral ----
      tick_to(110); mode_req = 3'd3; mode_wr = 1; tick(); mode_wr = 0;
      tick_to(130); mode_req = 3'd5; mode_wr = 1; tick(); mode_wr = 0;
      tick_to(150);
      chk("mode_midframe", 32'(mode_o), 0);
      tick_to(2 * FRAME - 1);
      chk("sync_wrap2", 32'(sync_o), 1);
      chk("mode_on_wrap", 32'(mode_o), 0);
      mode_req = 3'd2; mode_wr = 1; tick(); mode_wr = 0;
      chk("mode_last_wins", 32'(mode_o), 5);
      chk("frame_cnt_2", 32'(frame_cnt), 2);
      tick_to(3 * FRAME - 1);
      chk("mode_hold_5", 32'(mode_o), 5);
      tick();
      chk("mode_wrapwr_2", 32'(mode_o), 2);
      chk("frame_cnt_3", 32'(frame_cnt), 3);

      // ---- table-driven single transfers ----
      ack_en = 1'b1;
      foreach (vecs[i]) begin
         a0 = s0_ack_cnt; a1 = s1_ack_cnt;
         s0_stb = vecs[i].s0; s1_stb = vecs[i].s1;
         s0_data = vecs[i].d0; s1_data = vecs[i].d1;
         run_xfer(lat, src, seen, stbn);
         s0_stb = 0; s1_stb = 0;
         tick();
         chk($sformatf("v%0d_latency", i), 32'(lat), 3);
         chk($sformatf("v%0d_src", i), 32'(src), 32'(vecs[i].exp_src));
         chk($sformatf("v%0d_data", i), 32'(seen), 32'(vecs[i].exp_data));
         chk($sformatf("v%0d_stb_cycles", i), 32'(stbn), 1);
         chk($sformatf("v%0d_ack_pulses", i), 32'((s0_ack_cnt - a0) + (s1_ack_cnt - a1)), 1);
      end

      // ---- both sources streaming 4 bytes: strict alternation ----
      a0 = s0_ack_cnt; a1 = s1_ack_cnt;
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(8'hA0 + 8'(k)); src_q.push_back(8'd0);
         exp_q.push_back(8'hB0 + 8'(k)); src_q.push_back(8'd1);
      end
      both_cnt = 0;
      sb_en = 1'b1;
      i0 = 0; i1 = 0;
      s0_stb = 1; s0_data = 8'hA0; s1_stb = 1; s1_data = 8'hB0;
      for (int k = 0; k < 200 && (i0 < 4 || i1 < 4); k++) begin
         tick();
         if (s0_ack) i0++;
         if (s1_ack) i1++;
         s0_stb = (i0 < 4); s0_data = 8'hA0 + 8'(i0);
         s1_stb = (i1 < 4); s1_data = 8'hB0 + 8'(i1);
      end
      tick();
      sb_en = 1'b0;
      chk("alt_s0_acks", 32'(s0_ack_cnt - a0), 4);
      chk("alt_s1_acks", 32'(s1_ack_cnt - a1), 4);
      chk("alt_both_acks", 32'(both_cnt), 0);
      chk("alt_exp_left", 32'(exp_q.size()), 0);
      chk("alt_src_left", 32'(src_q.size()), 0);

      // ---- PPU never acks: timeout, retry, err_clr, set-wins ----
      ack_en = 1'b0;
      a0 = s0_ack_cnt;
      s0_stb = 1; s0_data = 8'h5A;
      for (int k = 1; k <= 36; k++) begin
         tick();
         case (k)
            1:  chk("to_stb", 32'(ppu_stb), 1);
            16: begin
               chk("to_err_before", 32'(err_o), 0);
               chk("to_state_wait", 32'(state_dbg), 2);
            end
            17: begin
               chk("to_err_set", 32'(err_o), 1);
               chk("to_state_idle", 32'(state_dbg), 0);
            end
            18: chk("to_retry_stb", 32'(ppu_stb), 1);
            19: err_clr = 1;
            20: begin
               err_clr = 0;
               s0_stb  = 0;
               chk("to_err_clr", 32'(err_o), 0);
            end
            33: err_clr = 1;
            34: chk("to_set_wins", 32'(err_o), 1);
            35: begin
               err_clr = 0;
               chk("to_err_clr2", 32'(err_o), 0);
            end
            default: ;
         endcase
      end
      chk("to_no_s0_ack", 32'(s0_ack_cnt - a0), 0);

      // ---- reset in WAIT with s1 granted ----
      a1 = s1_ack_cnt;
      s1_stb = 1; s1_data = 8'hC3;
      repeat (3) tick();
      chk("rw_state_wait", 32'(state_dbg), 2);
      chk("rw_data_s1", 32'(ppu_data), 32'h0C3);
      rst = 1'b0;
      #1;
      chk("rw_ppu_stb", 32'(ppu_stb), 0);
      chk("rw_state_idle", 32'(state_dbg), 0);
      chk("rw_ppu_data", 32'(ppu_data), 0);
      chk("rw_frame_cnt", 32'(frame_cnt), 0);
      chk("rw_mode", 32'(mode_o), 0);
      ack_en = 1'b1;
      repeat (3) tick();
      chk("rw_no_s1_ack", 32'(s1_ack_cnt - a1), 0);

      s0_stb = 1; s0_data = 8'h3C;
      rst = 1'b1;
      cyc = 0;
      run_xfer(lat, src, seen, stbn);
      s0_stb = 0; s1_stb = 0;
      chk("rw_first_src", 32'(src), 0);
      chk("rw_first_data", 32'(seen), 32'h03C);
      chk("rw_first_lat", 32'(lat), 3);

      first_sync = -1;
      while (cyc < FRAME + 1) begin
         tick();
         if (sync_o && first_sync < 0) first_sync = cyc;
      end
      chk("rw_sync_cycle", 32'(first_sync), 32'(FRAME - 1));

      chk("stb_single_cycle", 32'(stb_double), 0);
      chk("never_both_acks", 32'(both_cnt), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
